// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the FD opcode once into a one-hot control word and
// carries it through DX/XM/MW/WB, with load-use stall, branch flush and mul/div hold in XM.
module ctrl_pipe #(
  parameter int unsigned MD_LAT = 17,
  parameter int unsigned MD_EN  = 1,
  parameter int unsigned OP_W   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] fd_opcode,
  input  logic [4:0]      fd_aluop,
  input  logic            fd_valid,
  input  logic            fd_stall,
  input  logic            flush,
  output logic            hold_fd,
  output logic            md_busy,
  output logic            md_start,
  output logic            dx_valid,
  output logic            xm_valid,
  output logic            mw_valid,
  output logic            wb_valid,
  output logic            dx_reg_b_choose,
  output logic            dx_is_bex,
  output logic            xm_choose_alu_B,
  output logic            xm_alu_addi,
  output logic            xm_alu_sub,
  output logic            xm_is_jump,
  output logic            xm_is_bne,
  output logic            xm_is_blt,
  output logic            xm_is_jal,
  output logic            xm_is_jr,
  output logic            xm_is_setx,
  output logic            xm_is_bex,
  output logic [4:0]      xm_aluop,
  output logic            mw_wren_dmem,
  output logic            mw_wren_reg_d,
  output logic            wb_wren_reg_d,
  output logic            wb_choose_reg_din,
  output logic            wb_is_jal,
  output logic            wb_is_setx
);

  localparam int unsigned CntW = $clog2(MD_LAT + 1);
  localparam logic [CntW-1:0] LatC  = CntW'(MD_LAT);
  localparam logic [CntW-1:0] LatM1 = CntW'(MD_LAT - 1);

  localparam int unsigned IAlu  = 0;
  localparam int unsigned IJ    = 1;
  localparam int unsigned IBne  = 2;
  localparam int unsigned IJal  = 3;
  localparam int unsigned IJr   = 4;
  localparam int unsigned IAddi = 5;
  localparam int unsigned IBlt  = 6;
  localparam int unsigned ISw   = 7;
  localparam int unsigned ILw   = 8;
  localparam int unsigned ISetx = 9;
  localparam int unsigned IBex  = 10;

  typedef struct packed {
    logic [10:0] oh;
    logic [4:0]  aluop;
    logic        valid;
  } stage_t;

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  stage_t dx_q, dx_d, xm_q, xm_d, mw_q, mw_d, wb_q, wb_d;
  stage_t fd_word;
  md_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic start_q, start_d;
  logic hi_bits;
  logic unused_wb;

  function automatic logic is_md(stage_t s);
    return (MD_EN != 0) && s.valid && s.oh[IAlu] && (s.aluop[4:1] == 4'b0011);
  endfunction

  // Opcode bits above [4:0] force a nop.
  if (OP_W > 5) begin : g_hi
    assign hi_bits = |fd_opcode[OP_W-1:5];
  end else begin : g_no_hi
    assign hi_bits = 1'b0;
  end

  always_comb begin
    fd_word       = '0;
    fd_word.aluop = fd_aluop;
    fd_word.valid = fd_valid;
    if (!hi_bits) begin
      case (fd_opcode[4:0])
        5'b00000: fd_word.oh[IAlu]  = 1'b1;
        5'b00001: fd_word.oh[IJ]    = 1'b1;
        5'b00010: fd_word.oh[IBne]  = 1'b1;
        5'b00011: fd_word.oh[IJal]  = 1'b1;
        5'b00100: fd_word.oh[IJr]   = 1'b1;
        5'b00101: fd_word.oh[IAddi] = 1'b1;
        5'b00110: fd_word.oh[IBlt]  = 1'b1;
        5'b00111: fd_word.oh[ISw]   = 1'b1;
        5'b01000: fd_word.oh[ILw]   = 1'b1;
        5'b10101: fd_word.oh[ISetx] = 1'b1;
        5'b10110: fd_word.oh[IBex]  = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    dx_d    = dx_q;
    xm_d    = xm_q;
    mw_d    = mw_q;
    wb_d    = mw_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    if (md_busy) begin
      mw_d = '0;
    end else begin
      mw_d = xm_q;
      if (flush) begin
        dx_d = '0;
        xm_d = '0;
      end else if (fd_stall) begin
        xm_d = '0;
      end else begin
        xm_d    = dx_q;
        dx_d    = fd_word;
        start_d = is_md(dx_q);
      end
    end
    unique case (state_q)
      StIdle: begin
        if (start_d && (MD_LAT > 1)) begin
          state_d = StBusy;
          cnt_d   = CntW'(1);
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LatM1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dx_q    <= '0;
      xm_q    <= '0;
      mw_q    <= '0;
      wb_q    <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      dx_q    <= dx_d;
      xm_q    <= xm_d;
      mw_q    <= mw_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign md_busy  = (state_q == StBusy) && (cnt_q < LatC);
  assign md_start = start_q;
  assign hold_fd  = fd_stall | md_busy;

  assign dx_valid = dx_q.valid;
  assign xm_valid = xm_q.valid;
  assign mw_valid = mw_q.valid;
  assign wb_valid = wb_q.valid;

  assign dx_reg_b_choose = dx_q.valid & (dx_q.oh[ISw] | dx_q.oh[IBne] | dx_q.oh[IBlt]
                                         | dx_q.oh[IJr]);
  assign dx_is_bex       = dx_q.valid & dx_q.oh[IBex];

  assign xm_choose_alu_B = xm_q.valid & (xm_q.oh[IAddi] | xm_q.oh[ILw] | xm_q.oh[ISw]);
  assign xm_alu_addi     = xm_choose_alu_B;
  assign xm_alu_sub      = xm_q.valid & (xm_q.oh[IBlt] | xm_q.oh[IBne] | xm_q.oh[IBex]);
  assign xm_is_jump      = xm_q.valid & (xm_q.oh[IJ] | xm_q.oh[IJal] | xm_q.oh[IJr]);
  assign xm_is_bne       = xm_q.valid & xm_q.oh[IBne];
  assign xm_is_blt       = xm_q.valid & xm_q.oh[IBlt];
  assign xm_is_jal       = xm_q.valid & xm_q.oh[IJal];
  assign xm_is_jr        = xm_q.valid & xm_q.oh[IJr];
  assign xm_is_setx      = xm_q.valid & xm_q.oh[ISetx];
  assign xm_is_bex       = xm_q.valid & xm_q.oh[IBex];
  assign xm_aluop        = xm_q.valid ? xm_q.aluop : 5'd0;

  assign mw_wren_dmem  = mw_q.valid & mw_q.oh[ISw];
  assign mw_wren_reg_d = mw_q.valid & (mw_q.oh[IAlu] | mw_q.oh[IAddi] | mw_q.oh[ILw]
                                       | mw_q.oh[IJal] | mw_q.oh[ISetx]);

  assign wb_wren_reg_d     = wb_q.valid & (wb_q.oh[IAlu] | wb_q.oh[IAddi] | wb_q.oh[ILw]
                                           | wb_q.oh[IJal] | wb_q.oh[ISetx]);
  assign wb_choose_reg_din = wb_q.valid & wb_q.oh[ILw];
  assign wb_is_jal         = wb_q.valid & wb_q.oh[IJal];
  assign wb_is_setx        = wb_q.valid & wb_q.oh[ISetx];

  // WB only drives a few controls; the remaining word bits are intentionally dropped.
  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: three configurations (MD_LAT=4, MD_LAT=1, MD_EN=0) share one stimulus
// stream and are compared every cycle against an instruction-level pipeline model.
module tb_ctrl_pipe;

  localparam int OPW = 6;
  localparam logic [5:0] OpAlu  = 6'd0;
  localparam logic [5:0] OpJ    = 6'd1;
  localparam logic [5:0] OpBne  = 6'd2;
  localparam logic [5:0] OpJal  = 6'd3;
  localparam logic [5:0] OpJr   = 6'd4;
  localparam logic [5:0] OpAddi = 6'd5;
  localparam logic [5:0] OpBlt  = 6'd6;
  localparam logic [5:0] OpSw   = 6'd7;
  localparam logic [5:0] OpLw   = 6'd8;
  localparam logic [5:0] OpSetx = 6'd21;
  localparam logic [5:0] OpBex  = 6'd22;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [OPW-1:0] fd_opcode = '0;
  logic [4:0] fd_aluop = '0;
  logic fd_valid = 1'b0;
  logic fd_stall = 1'b0;
  logic flush = 1'b0;
  logic [29:0] got [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic hold_fd, md_busy, md_start, dx_valid, xm_valid, mw_valid, wb_valid;
    logic dx_reg_b_choose, dx_is_bex, xm_choose_alu_B, xm_alu_addi, xm_alu_sub, xm_is_jump;
    logic xm_is_bne, xm_is_blt, xm_is_jal, xm_is_jr, xm_is_setx, xm_is_bex;
    logic [4:0] xm_aluop;
    logic mw_wren_dmem, mw_wren_reg_d, wb_wren_reg_d, wb_choose_reg_din, wb_is_jal, wb_is_setx;

    ctrl_pipe #(
      .MD_LAT((g == 1) ? 1 : 4),
      .MD_EN ((g == 2) ? 0 : 1),
      .OP_W  (OPW)
    ) u_dut (
      .clock(clock), .reset(reset), .fd_opcode(fd_opcode), .fd_aluop(fd_aluop),
      .fd_valid(fd_valid), .fd_stall(fd_stall), .flush(flush), .hold_fd(hold_fd),
      .md_busy(md_busy), .md_start(md_start), .dx_valid(dx_valid), .xm_valid(xm_valid),
      .mw_valid(mw_valid), .wb_valid(wb_valid), .dx_reg_b_choose(dx_reg_b_choose),
      .dx_is_bex(dx_is_bex), .xm_choose_alu_B(xm_choose_alu_B), .xm_alu_addi(xm_alu_addi),
      .xm_alu_sub(xm_alu_sub), .xm_is_jump(xm_is_jump), .xm_is_bne(xm_is_bne),
      .xm_is_blt(xm_is_blt), .xm_is_jal(xm_is_jal), .xm_is_jr(xm_is_jr),
      .xm_is_setx(xm_is_setx), .xm_is_bex(xm_is_bex), .xm_aluop(xm_aluop),
      .mw_wren_dmem(mw_wren_dmem), .mw_wren_reg_d(mw_wren_reg_d),
      .wb_wren_reg_d(wb_wren_reg_d), .wb_choose_reg_din(wb_choose_reg_din),
      .wb_is_jal(wb_is_jal), .wb_is_setx(wb_is_setx)
    );

    assign got[g] = {hold_fd, md_busy, md_start, dx_valid, xm_valid, mw_valid, wb_valid,
                     dx_reg_b_choose, dx_is_bex, xm_choose_alu_B, xm_alu_addi, xm_alu_sub,
                     xm_is_jump, xm_is_bne, xm_is_blt, xm_is_jal, xm_is_jr, xm_is_setx,
                     xm_is_bex, xm_aluop, mw_wren_dmem, mw_wren_reg_d, wb_wren_reg_d,
                     wb_choose_reg_din, wb_is_jal, wb_is_setx};
  end

  // Instruction-level model: each stage holds the instruction record; age counts XM cycles.
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] alu;
    logic       v;
  } rec_t;

  rec_t m_dx [3];
  rec_t m_xm [3];
  rec_t m_mw [3];
  rec_t m_wb [3];
  int age [3];
  int lat [3] = '{4, 1, 4};
  bit en [3] = '{1'b1, 1'b1, 1'b0};

  function automatic bit has(rec_t r, logic [5:0] o);
    return r.v && (r.op == o);
  endfunction

  function automatic bit writes_reg(rec_t r);
    return has(r, OpAlu) || has(r, OpAddi) || has(r, OpLw) || has(r, OpJal) || has(r, OpSetx);
  endfunction

  function automatic bit is_md(int k, rec_t r);
    return en[k] && has(r, OpAlu) && (r.alu == 5'd6 || r.alu == 5'd7);
  endfunction

  function automatic bit m_busy(int k);
    return is_md(k, m_xm[k]) && (age[k] < lat[k]);
  endfunction

  function automatic logic [29:0] exp_vec(int k);
    rec_t d = m_dx[k];
    rec_t x = m_xm[k];
    rec_t m = m_mw[k];
    rec_t w = m_wb[k];
    bit busy = m_busy(k);
    bit start = is_md(k, x) && (age[k] == 1);
    bit alub = has(x, OpAddi) || has(x, OpLw) || has(x, OpSw);
    return {fd_stall | busy, busy, start, d.v, x.v, m.v, w.v,
            has(d, OpSw) || has(d, OpBne) || has(d, OpBlt) || has(d, OpJr), has(d, OpBex),
            alub, alub, has(x, OpBlt) || has(x, OpBne) || has(x, OpBex),
            has(x, OpJ) || has(x, OpJal) || has(x, OpJr), has(x, OpBne), has(x, OpBlt),
            has(x, OpJal), has(x, OpJr), has(x, OpSetx), has(x, OpBex),
            x.v ? x.alu : 5'd0,
            has(m, OpSw), writes_reg(m), writes_reg(w), has(w, OpLw), has(w, OpJal),
            has(w, OpSetx)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_dx[k] = '0; m_xm[k] = '0; m_mw[k] = '0; m_wb[k] = '0; age[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit busy = m_busy(k);
      m_wb[k] = m_mw[k];
      if (busy) begin
        m_mw[k] = '0;
        age[k]  = age[k] + 1;
      end else begin
        m_mw[k] = m_xm[k];
        if (flush) begin
          m_xm[k] = '0;
          m_dx[k] = '0;
        end else if (fd_stall) begin
          m_xm[k] = '0;
        end else begin
          m_xm[k] = m_dx[k];
          m_dx[k] = '{op: fd_opcode, alu: fd_aluop, v: fd_valid};
        end
        age[k] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      logic [29:0] exp = exp_vec(k);
      vectors++;
      assert (got[k] === exp)
      else begin
        miscompares++;
        $error("FAIL %s cfg%0d t=%0t got=%h exp=%h", tag, k, $time, got[k], exp);
      end
    end
  endtask

  // Drive one FD slot, check outputs before the edge, then advance the model with the edge.
  task automatic step(input logic [5:0] op, input logic [4:0] alu, input logic v,
                      input logic st, input logic fl);
    fd_opcode = op; fd_aluop = alu; fd_valid = v; fd_stall = st; flush = fl;
    #1 check_all("pipe");
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(OpAlu, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [5:0] op_tab [16] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
                              6'd6, 6'd7, 6'd8, 6'd21, 6'd22, 6'd9, 6'd32, 6'd35};

  initial begin
    model_reset();
    #2 check_all("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Mixed stream
    step(OpAlu, 5'd0, 1, 0, 0);
    step(OpAddi, 5'd0, 1, 0, 0);
    step(OpSw, 5'd0, 1, 0, 0);
    step(OpLw, 5'd0, 1, 0, 0);
    step(OpJal, 5'd0, 1, 0, 0);
    step(OpSetx, 5'd0, 1, 0, 0);
    step(OpBne, 5'd1, 1, 0, 0);
    step(OpBex, 5'd1, 1, 0, 0);
    step(OpJ, 5'd0, 1, 0, 0);
    step(OpJr, 5'd0, 1, 0, 0);
    step(OpBlt, 5'd1, 1, 0, 0);
    nops(4);

    // Load-use stall with lw in DX
    step(OpLw, 5'd0, 1, 0, 0);
    step(OpAlu, 5'd2, 1, 1, 0);
    step(OpAlu, 5'd2, 1, 0, 0);
    nops(4);

    // Taken branch in XM kills DX and FD
    step(OpBne, 5'd1, 1, 0, 0);
    step(OpAddi, 5'd0, 1, 0, 0);
    step(OpAlu, 5'd3, 1, 0, 1);
    nops(4);

    // Single mul, then div with flush/stall during the hold
    step(OpAlu, 5'd6, 1, 0, 0);
    step(OpAddi, 5'd0, 1, 0, 0);
    nops(7);
    step(OpAlu, 5'd7, 1, 0, 0);
    step(OpSw, 5'd0, 1, 0, 0);
    step(OpLw, 5'd0, 1, 1, 0);
    step(OpLw, 5'd0, 1, 0, 1);
    step(OpLw, 5'd0, 1, 1, 1);
    nops(6);

    // Back-to-back mul/div
    step(OpAlu, 5'd6, 1, 0, 0);
    step(OpAlu, 5'd7, 1, 0, 0);
    step(OpAlu, 5'd6, 1, 0, 0);
    nops(14);

    // Asynchronous reset in the middle of a hold
    step(OpAlu, 5'd6, 1, 0, 0);
    nops(3);
    fd_stall = 1'b0; flush = 1'b0; fd_valid = 1'b0;
    reset = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clock);
    #1 check_all("rst_held");
    #2 reset = 1'b1;
    step(OpAlu, 5'd7, 1, 0, 0);
    nops(8);

    // Opcodes that must decode as nop
    step(6'd9, 5'd0, 1, 0, 0);
    step(6'd32, 5'd0, 1, 0, 0);
    step(6'd35, 5'd6, 1, 0, 0);
    nops(4);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      logic [4:0] alu;
      op = op_tab[$urandom_range(0, 15)];
      if ($urandom_range(0, 3) == 0) alu = 5'(6 + $urandom_range(0, 1));
      else alu = 5'($urandom_range(0, 31));
      step(op, alu, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0);
    end
    nops(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the 5-stage core. It decodes the FD-stage opcode once into a one-hot control word and carries that word, with a valid bit, through DX/XM/MW/WB stage registers. It implements load-use stall, taken-branch flush and a counter-driven multiply/divide hold in XM. It replaces per-stage opcode re-decoding and sits beside the datapath latches, driving every mux and write-enable select.

## Interface
- `MD_LAT`, default 17: cycles a mul/div occupies XM. Must be ≥1; 1 means no hold.
- `MD_EN`, default 1: 0 treats mul/div as ordinary ALU ops and never asserts `md_busy`.
- `OP_W`, default 5: opcode width. Must be ≥5; a nonzero bit above [4:0] decodes as nop.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `fd_opcode`  in  OP_W  opcode of the instruction in FD.
- `fd_aluop`  in  5  ALU op field of that instruction.
- `fd_valid`  in  1  FD holds a real instruction.
- `fd_stall`  in  1  load-use hazard from the hazard unit.
- `flush`  in  1  branch/jump taken, resolved in XM.
- `hold_fd`  out  1  `fd_stall | md_busy`; freezes PC and the FD latch.
- `md_busy`, `md_start`  out  1 each  multdiv hold active / first XM cycle of a mul/div.
- `dx_valid`, `xm_valid`, `mw_valid`, `wb_valid`  out  1 each  stage holds a real instruction.
- `dx_reg_b_choose`, `dx_is_bex`  out  1 each.
- `xm_choose_alu_B`, `xm_alu_addi`, `xm_alu_sub`, `xm_is_jump`, `xm_is_bne`, `xm_is_blt`, `xm_is_jal`, `xm_is_jr`, `xm_is_setx`, `xm_is_bex`  out  1 each.
- `xm_aluop`  out  5  ALU op of the XM instruction.
- `mw_wren_dmem`, `mw_wren_reg_d`  out  1 each.
- `wb_wren_reg_d`, `wb_choose_reg_din`, `wb_is_jal`, `wb_is_setx`  out  1 each.

## Operation
- Opcode decode: alu 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110. Any other code is a valid nop with all controls 0.
- Stage word: 11 one-hot bits, aluop[4:0] and valid. Every output is that stage's decode ANDed with its valid bit, so a bubble drives all controls to 0.
- Output equations:
  - `reg_b_choose` = sw|bne|blt|jr
  - `choose_alu_B` = `alu_addi` = addi|lw|sw
  - `alu_sub` = blt|bne|bex
  - `is_jump` = j|jal|jr
  - `wren_dmem` = sw
  - `wren_reg_d` = alu|addi|lw|jal|setx
  - `choose_reg_din` = lw
- Mul/div: alu opcode with aluop 00110 or 00111, and `MD_EN`=1.
- Counter state machine:
  - IDLE→BUSY when a valid mul/div enters XM and `MD_LAT`>1.
  - `md_start` is high in the first XM cycle; counter loads 1.
  - BUSY: counter increments each cycle; `md_busy` = (state BUSY) and (counter < `MD_LAT`).
  - BUSY→IDLE on the cycle counter == `MD_LAT`-1; the instruction advances to MW at the next edge.
  - Counter width is clog2(`MD_LAT`+1).
- Advance priority per edge, highest first:
  - `md_busy`: DX and XM hold; MW loads a bubble; WB takes MW. `flush` and `fd_stall` are ignored.
  - `flush`: DX loads a bubble (FD killed); XM loads a bubble (DX killed); MW←XM; WB←MW.
  - `fd_stall`: DX holds; XM loads a bubble; MW←XM; WB←MW.
  - Otherwise all stages shift. DX loads decode(FD) with valid = `fd_valid`.
- Reset mid-operation clears all valid bits, the counter and the state machine; any in-flight mul/div is abandoned.

## Timing
- Every output except `hold_fd` is a function of registered state only; there is no combinational path from inputs.
- `hold_fd` is combinational from `fd_stall` and registered `md_busy`.
- Reset values: all valid bits, all controls, `xm_aluop`, `md_busy`, `md_start` and `hold_fd` (excluding `fd_stall`) are 0.
- Latency: an instruction in FD at edge n appears in DX after n, XM after n+1, MW after n+2, WB after n+3, with no hazards.
- A mul/div stays in XM for exactly `MD_LAT` cycles; `md_busy` is high for `MD_LAT`-1 of them.
- Back-to-back mul/div: the second enters XM on the edge the first leaves, and `md_start` pulses again on the next cycle. There are no idle cycles between them.

## Test plan
- Reset then a stream of add, addi, sw, lw, jal, setx, bne, bex → each stage's controls match the equations, skewed by 1 cycle per stage. Example: lw gives `wb_choose_reg_din`=1 and `wb_wren_reg_d`=1 exactly 4 cycles after entering FD.
- lw in DX with `fd_stall`=1 for 1 cycle → DX holds lw, XM carries a bubble (all 0, `xm_valid`=0), `hold_fd`=1 that cycle.
- bne in XM with `flush`=1 → next cycle `dx_valid`=`xm_valid`=0, `mw_valid`=1, and no `wren` for the two killed instructions.
- mul (aluop 00110) with `MD_LAT`=4 → `md_start` for 1 cycle; `md_busy` high 3 cycles; mul in XM 4 cycles; 3 bubbles into MW; `mw_wren_reg_d`=1 on the 5th cycle.
- `flush` and `fd_stall` asserted while `md_busy`=1 → ignored; `MD_LAT`=1 → no `md_busy`; `MD_EN`=0 → mul flows like add.
- Async reset (`reset`=0) mid mul/div hold → all outputs 0 immediately; after release a fresh mul gets the full `MD_LAT` count.
